eight_to_one: RTL and testbench

//  8:1 single-bit multiplexer: out = dat[sel]. Three structurally different but

---
 rtl/eight_to_one.sv | 75 +++++++
 tb/tb_eight_to_one.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/eight_to_one.sv
// 8:1 single-bit mux (out = dat[sel]) with three selectable structures; out is zero-latency,
// q is out registered with 1-cycle latency. No flow control, accepts new inputs every cycle.
module eight_to_one #(
  parameter bit SEVEN_SEVEN_STYLE = 1'b0,
  parameter bit FIVE_FIVE_STYLE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dat,
  input  logic [2:0] sel,
  output logic       out,
  output logic       q
);

  logic mux_w;
  logic q_d;
  logic q_q;

  generate
    if (SEVEN_SEVEN_STYLE) begin : g_seven_seven
      // f0 sees only the low nibble and sel; f1 folds in the high nibble plus f0.
      logic f0;
      logic f1;
      always_comb begin
        f0    = sel[2] ? 1'b0 : dat[{1'b0, sel[1:0]}];
        f1    = sel[2] ? dat[{1'b1, sel[1:0]}] : f0;
        mux_w = f1;
      end
    end else if (FIVE_FIVE_STYLE) begin : g_five_five
      logic g0;
      logic g1;
      logic g2;
      logic g3;
      logic h;
      always_comb begin
        g0    = sel[0] ? dat[1] : dat[0];
        g1    = sel[0] ? dat[3] : dat[2];
        g2    = sel[0] ? dat[5] : dat[4];
        g3    = sel[0] ? dat[7] : dat[6];
        h     = sel[1] ? (sel[2] ? g3 : g1) : (sel[2] ? g2 : g0);
        mux_w = h;
      end
    end else begin : g_generic
      logic lo;
      logic hi;
      always_comb begin
        lo = 1'b0;
        hi = 1'b0;
        case (sel[1:0])
          2'd0: begin lo = dat[0]; hi = dat[4]; end
          2'd1: begin lo = dat[1]; hi = dat[5]; end
          2'd2: begin lo = dat[2]; hi = dat[6]; end
          default: begin lo = dat[3]; hi = dat[7]; end
        endcase
        mux_w = sel[2] ? hi : lo;
      end
    end
  endgenerate

  always_comb begin
    q_d = mux_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign out = mux_w;
  assign q   = q_q;

endmodule

// File: tb/tb_eight_to_one.sv
// Bench for eight_to_one: three style variants on shared inputs, checked against a shift-based reference.
module tb_eight_to_one;

  logic       clk;
  logic       rst_n;
  logic [7:0] dat;
  logic [2:0] sel;
  logic       out_ss, out_ff, out_gen;
  logic       q_ss, q_ff, q_gen;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic       e;
  } vec_t;

  vec_t tbl[7];

  eight_to_one #(.SEVEN_SEVEN_STYLE(1'b1), .FIVE_FIVE_STYLE(1'b0)) u_ss (
    .clk(clk), .rst_n(rst_n), .dat(dat), .sel(sel), .out(out_ss), .q(q_ss));
  eight_to_one #(.SEVEN_SEVEN_STYLE(1'b0), .FIVE_FIVE_STYLE(1'b1)) u_ff (
    .clk(clk), .rst_n(rst_n), .dat(dat), .sel(sel), .out(out_ff), .q(q_ff));
  eight_to_one #(.SEVEN_SEVEN_STYLE(1'b0), .FIVE_FIVE_STYLE(1'b0)) u_gen (
    .clk(clk), .rst_n(rst_n), .dat(dat), .sel(sel), .out(out_gen), .q(q_gen));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected bit is what lands in the LSB after shifting right by sel.
  function automatic logic ref_mux(input logic [7:0] d, input logic [2:0] s);
    int v;
    v = int'(d) >> int'(s);
    return (v % 2) == 1;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dat=%h sel=%0d rst_n=%b got=%b expected=%b", nm, dat, sel, rst_n, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic exp);
    chk({nm, "_out_ss"},  out_ss,  exp);
    chk({nm, "_out_ff"},  out_ff,  exp);
    chk({nm, "_out_gen"}, out_gen, exp);
  endtask

  task automatic chk_q(input string nm, input logic exp);
    chk({nm, "_q_ss"},  q_ss,  exp);
    chk({nm, "_q_ff"},  q_ff,  exp);
    chk({nm, "_q_gen"}, q_gen, exp);
  endtask

  initial begin
    logic exp_q;
    n_checks = 0;
    n_errors = 0;

    tbl[0] = '{d: 8'b1000_0000, s: 3'd7, e: 1'b1};
    tbl[1] = '{d: 8'b1000_0000, s: 3'd6, e: 1'b0};
    tbl[2] = '{d: 8'h01,        s: 3'd0, e: 1'b1};
    tbl[3] = '{d: 8'hA5,        s: 3'd2, e: 1'b1};
    tbl[4] = '{d: 8'hA5,        s: 3'd1, e: 1'b0};
    tbl[5] = '{d: 8'h7F,        s: 3'd7, e: 1'b0};
    tbl[6] = '{d: 8'hFE,        s: 3'd0, e: 1'b0};

    rst_n = 1'b0;
    dat   = 8'hFF;
    sel   = 3'd0;
    @(posedge clk);
    #1;
    chk_q("reset", 1'b0);

    // Directed table.
    foreach (tbl[i]) begin
      @(negedge clk);
      dat = tbl[i].d;
      sel = tbl[i].s;
      #1;
      chk_out("table", tbl[i].e);
    end

    // Exhaustive sweep of all dat/sel combinations.
    for (int d = 0; d < 256; d++) begin
      for (int s = 0; s < 8; s++) begin
        @(negedge clk);
        dat = 8'(d);
        sel = 3'(s);
        #1;
        chk_out("exh", ref_mux(dat, sel));
      end
    end

    // Random combinational vectors.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      dat = 8'($urandom);
      sel = 3'($urandom);
      #1;
      chk_out("rnd", ref_mux(dat, sel));
    end

    // Register: hand sequence from reset release.
    @(negedge clk);
    rst_n = 1'b1;
    dat   = 8'hA5;
    sel   = 3'd2;
    @(posedge clk);
    #1;
    chk_q("reg_a5_s2", 1'b1);
    @(negedge clk);
    sel = 3'd1;
    #1;
    chk_q("reg_hold", 1'b1);
    @(posedge clk);
    #1;
    chk_q("reg_a5_s1", 1'b0);

    // Async reset mid-cycle while q is 1.
    @(negedge clk);
    sel = 3'd0;
    @(posedge clk);
    #1;
    chk_q("pre_rst", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_q("async_rst", 1'b0);
    @(posedge clk);
    #1;
    chk_q("rst_held", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_q("rel_before_edge", 1'b0);
    @(posedge clk);
    #1;
    chk_q("rel_after_edge", 1'b1);

    // Random register stream with occasional async reset pulses.
    exp_q = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      dat   = 8'($urandom);
      sel   = 3'($urandom);
      rst_n = ($urandom_range(0, 9) != 0);
      #1;
      if (!rst_n) exp_q = 1'b0;
      chk_q("rreg_neg", exp_q);
      chk_out("rreg_out", ref_mux(dat, sel));
      @(posedge clk);
      #1;
      exp_q = rst_n ? ref_mux(dat, sel) : 1'b0;
      chk_q("rreg_pos", exp_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
